// File: rtl/uart_mem_responder_pkg.sv
// Shared definitions for the memory-side UART line-transfer responder.
package uart_mem_responder_pkg;

  localparam int DEF_ADDR_BYTES = 4;
  localparam int DEF_LINE_BYTES = 32;
  localparam int OP_BIT         = 31;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_CMD = 3'd0,
    S_MRD = 3'd1,
    S_TX  = 3'd2,
    S_RXD = 3'd3,
    S_MWR = 3'd4
  } state_e;

endpackage

// File: rtl/uart_mem_responder_gate.sv
// Pop/push strobe generator: fires at most once every two cycles so the FIFO
// has a cycle to advance its head before the next transfer is considered.
module uart_byte_gate (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic ready,
  output logic fire,
  output logic flag
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    fire   = en && ready && !flag_q;
    flag_d = fire;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/uart_mem_responder.sv
// Memory-side responder: decodes a command word from the rx byte stream and
// either streams a memory line out over tx or commits a received line.
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int ADDR_BYTES = DEF_ADDR_BYTES,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    receivable,
  input  logic [7:0]              recv_data,
  output logic                    recv_flag,
  input  logic                    sendable,
  output logic [7:0]              send_data,
  output logic                    send_flag,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy
);

  localparam int CMD_W  = ADDR_BYTES * 8;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CW     = $clog2(LINE_BYTES) + 1;
  localparam int CMD_IW = $clog2(ADDR_BYTES);

  localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] LINE_LAST = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0] LINE_DONE = CW'(LINE_BYTES);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          send_data_q, send_data_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;

  logic                rx_en, rx_fire;
  logic                tx_en, tx_fire;
  logic [CMD_IW+2:0]   cmd_off;
  logic [CW+1:0]       line_off;

  // Bytes are only taken from the FIFO while collecting a command or write data;
  // anything queued behind a read stays put until the response has gone out.
  assign rx_en = (state_q == S_CMD) || (state_q == S_RXD);
  assign tx_en = (state_q == S_TX) && (cnt_q != LINE_DONE);

  uart_byte_gate u_rx_gate (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (rx_en),
    .ready (receivable),
    .fire  (rx_fire),
    .flag  (recv_flag)
  );

  uart_byte_gate u_tx_gate (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (tx_en),
    .ready (sendable),
    .fire  (tx_fire),
    .flag  (send_flag)
  );

  assign cmd_off  = {cnt_q[CMD_IW-1:0], 3'b000};
  assign line_off = {cnt_q[CW-2:0], 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    line_d      = line_q;
    wdata_d     = wdata_q;
    send_data_d = send_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      S_CMD: begin
        if (rx_fire) begin
          cmd_d[cmd_off +: 8] = recv_data;
          if (cnt_q == CMD_LAST) begin
            cnt_d      = '0;
            mem_addr_d = {1'b0, cmd_d[OP_BIT-1:0]};
            if (cmd_d[OP_BIT] == OP_READ) begin
              state_d   = S_MRD;
              mem_req_d = 1'b1;
              mem_we_d  = 1'b0;
            end else begin
              state_d = S_RXD;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_MRD: begin
        if (mem_ack) begin
          line_d    = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_TX;
        end
      end

      S_TX: begin
        if (tx_fire) begin
          send_data_d = line_q[line_off +: 8];
          cnt_d       = cnt_q + CW'(1);
        end else if ((cnt_q == LINE_DONE) && send_flag) begin
          // Leave only once the final push strobe is on the wire.
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end

      S_RXD: begin
        if (rx_fire) begin
          wdata_d[line_off +: 8] = recv_data;
          if (cnt_q == LINE_LAST) begin
            cnt_d     = '0;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
            state_d   = S_MWR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_MWR: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_CMD;
        end
      end

      default: begin
        state_d = S_CMD;
        cnt_d   = '0;
      end
    endcase

    busy_d = !((state_d == S_CMD) && (cnt_d == '0));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_CMD;
      cnt_q       <= '0;
      cmd_q       <= '0;
      line_q      <= '0;
      wdata_q     <= '0;
      send_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      line_q      <= line_d;
      wdata_q     <= wdata_d;
      send_data_q <= send_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign send_data = send_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_mem_responder.sv
// Bench for uart_mem_responder: FIFO/memory models plus a line-level reference.
module tb_uart_mem_responder;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         receivable = 1'b0;
  logic [7:0]   recv_data = 8'h00;
  logic         recv_flag;
  logic         sendable = 1'b1;
  logic [7:0]   send_data;
  logic         send_flag;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         busy;

  uart_mem_responder dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .receivable (receivable),
    .recv_data  (recv_data),
    .recv_flag  (recv_flag),
    .sendable   (sendable),
    .send_data  (send_data),
    .send_flag  (send_flag),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } acc_t;

  logic [7:0]   rx_q[$];
  logic [7:0]   tx_q[$];
  acc_t         log_q[$];
  int           pop_push[$];
  logic [255:0] dev_mem[logic [31:0]];
  logic [255:0] ref_mem[logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0, push_cnt = 0;
  int rflag_viol = 0, sflag_viol = 0;
  bit prev_recv = 0, prev_send = 0;
  bit bp_mode = 0;
  int bp_cnt = 0;
  int ack_delay = 0, wait_cnt = 0;
  int spur_req = 0, spur_done = 0;

  // Initial memory contents: line at 0x40 holds bytes 0x00..0x1F.
  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = (a[7:0] - 8'h40 + 8'(i)) ^ a[15:8] ^ a[23:16];
    return l;
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // rx FIFO, tx sink, strobe-spacing monitor and sendable pattern
  always @(negedge CLK) begin
    if (send_flag) begin
      tx_q.push_back(send_data);
      push_cnt++;
    end
    if (recv_flag) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_cnt++;
      pop_push.push_back(push_cnt);
    end
    if (recv_flag && prev_recv) rflag_viol++;
    if (send_flag && prev_send) sflag_viol++;
    prev_recv  = recv_flag;
    prev_send  = send_flag;
    receivable = (rx_q.size() > 0);
    recv_data  = receivable ? rx_q[0] : 8'h00;
    if (bp_mode) begin
      bp_cnt++;
      sendable = ((bp_cnt / 3) % 2) == 0;
    end else begin
      sendable = 1'b1;
    end
  end

  // Line memory: acks after ack_delay cycles of mem_req; rdata is noise otherwise.
  always @(negedge CLK) begin
    acc_t e;
    mem_ack   = 1'b0;
    mem_rdata = {8{$urandom}};
    if (spur_req != spur_done) begin
      mem_ack = 1'b1;
      spur_done++;
    end else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        e.we     = mem_we;
        e.addr   = mem_addr;
        e.wdata  = mem_wdata;
        if (mem_we) dev_mem[mem_addr] = mem_wdata;
        else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_line(mem_addr);
        log_q.push_back(e);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic send_cmd(input logic op, input logic [30:0] a);
    logic [31:0] c;
    c = {op, a};
    for (int i = 0; i < 4; i++) rx_q.push_back(c[i*8 +: 8]);
  endtask

  task automatic send_line(input logic [255:0] d);
    for (int i = 0; i < 32; i++) rx_q.push_back(d[i*8 +: 8]);
  endtask

  function automatic logic [255:0] tx_line();
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 32 && i < tx_q.size(); i++) l[i*8 +: 8] = tx_q[i];
    return l;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (rx_q.size() == 0 && !busy && !recv_flag && !mem_req) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_idle"}, ok, 1);
  endtask

  task automatic do_txn(input string tag, input logic op, input logic [30:0] a,
                        input logic [255:0] d, input int delay, input bit bp);
    int base_log;
    logic [31:0] ea;
    logic [255:0] exp_line;
    ack_delay = delay;
    bp_mode   = bp;
    tx_q.delete();
    base_log  = log_q.size();
    ea        = {1'b0, a};
    exp_line  = ref_line(ea);
    send_cmd(op, a);
    if (op) send_line(d);
    wait_idle(tag, 4000);
    bp_mode = 0;
    chk({tag, "_nacc"}, log_q.size(), base_log + 1);
    if (log_q.size() > base_log) begin
      chk({tag, "_we"}, log_q[base_log].we, op);
      chk({tag, "_addr"}, log_q[base_log].addr, ea);
      if (op) chk({tag, "_wdata"}, log_q[base_log].wdata, d);
    end
    if (op) begin
      chk({tag, "_ntx"}, tx_q.size(), 0);
      ref_mem[ea] = d;
    end else begin
      chk({tag, "_ntx"}, tx_q.size(), 32);
      chk({tag, "_rline"}, tx_line(), exp_line);
    end
  endtask

  initial begin
    logic [255:0] d, exp_l;
    logic [30:0]  pool[4];
    int base_log, base_pop, base_push;
    bit seen, stable;

    // reset
    #1 RST_N = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_recv_flag", recv_flag, 0);
    chk("rst_send_flag", send_flag, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_send_data", send_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // directed read of 0x40 with the ack held off for 50 cycles
    ack_delay = 50;
    tx_q.delete();
    base_log = log_q.size();
    send_cmd(1'b0, 31'h40);
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (mem_req) begin
        seen = 1;
        break;
      end
    end
    chk("rd_req_seen", seen, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 32'h0000_0040);
    stable = 1;
    repeat (45) begin
      @(negedge CLK);
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) stable = 0;
    end
    chk("rd_req_hold", stable, 1);
    wait_idle("rd", 2000);
    for (int i = 0; i < 32; i++) exp_l[i*8 +: 8] = 8'(i);
    chk("rd_ntx", tx_q.size(), 32);
    chk("rd_line", tx_line(), exp_l);
    chk("rd_nacc", log_q.size(), base_log + 1);
    chk("rd_busy_after", busy, 0);

    // spurious ack while idle
    tx_q.delete();
    base_log = log_q.size();
    spur_req++;
    repeat (4) @(negedge CLK);
    chk("spur_busy", busy, 0);
    chk("spur_req", mem_req, 0);
    chk("spur_nacc", log_q.size(), base_log);
    chk("spur_ntx", tx_q.size(), 0);

    // directed write 0x80000080 with data 0xA0..0xBF
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);
    do_txn("wr", 1'b1, 31'h80, d, 3, 0);
    chk("wr_b0", log_q[log_q.size()-1].wdata[7:0], 8'hA0);
    chk("wr_b31", log_q[log_q.size()-1].wdata[255:248], 8'hBF);
    chk("rflag_gap_wr", rflag_viol, 0);

    // read then write to the same line queued together, tx backpressure
    tx_q.delete();
    base_log  = log_q.size();
    base_pop  = pop_cnt;
    base_push = push_cnt;
    exp_l     = ref_line(32'h1234_5660);
    d         = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ack_delay = 2;
    bp_mode   = 1;
    send_cmd(1'b0, 31'h1234_5660);
    send_cmd(1'b1, 31'h1234_5660);
    send_line(d);
    wait_idle("b2b", 4000);
    bp_mode = 0;
    chk("b2b_nacc", log_q.size(), base_log + 2);
    chk("b2b_rd_we", log_q[base_log].we, 0);
    chk("b2b_rd_addr", log_q[base_log].addr, 32'h1234_5660);
    chk("b2b_wr_we", log_q[base_log+1].we, 1);
    chk("b2b_wr_wdata", log_q[base_log+1].wdata, d);
    chk("b2b_ntx", tx_q.size(), 32);
    chk("b2b_rline", tx_line(), exp_l);
    chk("b2b_order", (pop_push.size() > base_pop + 4) ? pop_push[base_pop+4] - base_push : -1, 32);
    chk("sflag_gap_b2b", sflag_viol, 0);
    ref_mem[32'h1234_5660] = d;

    // reset after 10 write-data bytes
    base_log = log_q.size();
    base_pop = pop_cnt;
    send_cmd(1'b1, 31'h200);
    for (int i = 0; i < 10; i++) rx_q.push_back(8'h11 + 8'(i));
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (pop_cnt >= base_pop + 14 && rx_q.size() == 0) begin
        seen = 1;
        break;
      end
    end
    chk("mid_rst_reached", seen, 1);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_recv_flag", recv_flag, 0);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_send_data", send_data, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("mid_rst_nacc", log_q.size(), base_log);
    do_txn("post_rst_rd", 1'b0, 31'h200, '0, 1, 0);

    // randomized mix over a small address pool
    for (int i = 0; i < 4; i++) pool[i] = 31'($urandom) & ~31'h1F;
    for (int t = 0; t < 24; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
             d, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    chk("rflag_gap_all", rflag_viol, 0);
    chk("sflag_gap_all", sflag_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
